// File: rtl/chip8_pkg.sv
// Shared CHIP-8 definitions: ALU op codes, VF index, 8XYN sequencer state
// encoding and opcode field slice helpers.
package chip8_pkg;

  localparam int unsigned OPC_W  = 16;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned DATA_W = 8;

  // ALU op codes (the N nibble of 8XYN)
  localparam logic [NIB_W-1:0] ALU_LD  = 4'h0;
  localparam logic [NIB_W-1:0] ALU_OR  = 4'h1;
  localparam logic [NIB_W-1:0] ALU_AND = 4'h2;
  localparam logic [NIB_W-1:0] ALU_XOR = 4'h3;
  localparam logic [NIB_W-1:0] ALU_ADD = 4'h4;
  localparam logic [NIB_W-1:0] ALU_SUB = 4'h5;
  localparam logic [NIB_W-1:0] ALU_SHR = 4'h6;
  localparam logic [NIB_W-1:0] ALU_RSB = 4'h7;
  localparam logic [NIB_W-1:0] ALU_SHL = 4'hE;

  // Opcode class of the 8XYN group
  localparam logic [NIB_W-1:0] OPC_CLASS_ALU = 4'h8;

  // Flag register index
  localparam logic [NIB_W-1:0] C8_VF_IDX = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXEC = 3'd2,
    ST_WB_X = 3'd3,
    ST_WB_F = 3'd4,
    ST_DONE = 3'd5
  } seq_state_e;

  function automatic logic [NIB_W-1:0] op_class(input logic [OPC_W-1:0] opc);
    return opc[15:12];
  endfunction

  function automatic logic [NIB_W-1:0] op_x(input logic [OPC_W-1:0] opc);
    return opc[11:8];
  endfunction

  function automatic logic [NIB_W-1:0] op_y(input logic [OPC_W-1:0] opc);
    return opc[7:4];
  endfunction

  function automatic logic [NIB_W-1:0] op_n(input logic [OPC_W-1:0] opc);
    return opc[3:0];
  endfunction

endpackage

// File: rtl/chip8_8xy_decode.sv
// Combinational 8XYN decoder: splits the opcode into x/y/n and classifies it.
// Ports: opcode in; x, y, n fields out; legal (supported 8XYN);
// needs_vf_reset (logic op that also clears VF, only with
// CHIP8_QUIRK_VF_RESET_EN defined).
module chip8_8xy_decode
  import chip8_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output logic [NIB_W-1:0] x,
  output logic [NIB_W-1:0] y,
  output logic [NIB_W-1:0] n,
  output logic             legal,
  output logic             needs_vf_reset
);

  always_comb begin
    x              = op_x(opcode);
    y              = op_y(opcode);
    n              = op_n(opcode);
    legal          = 1'b0;
    needs_vf_reset = 1'b0;
    if (op_class(opcode) == OPC_CLASS_ALU) begin
      case (op_n(opcode))
        ALU_LD, ALU_OR, ALU_AND, ALU_XOR,
        ALU_ADD, ALU_SUB, ALU_SHR, ALU_RSB, ALU_SHL: legal = 1'b1;
        default:                                    legal = 1'b0;
      endcase
    end
`ifdef CHIP8_QUIRK_VF_RESET_EN
    // COSMAC VIP: OR/AND/XOR clobber VF with 0
    needs_vf_reset = legal && ((op_n(opcode) == ALU_OR) ||
                               (op_n(opcode) == ALU_AND) ||
                               (op_n(opcode) == ALU_XOR));
`endif
  end

endmodule

// File: rtl/chip8_alu_sequencer.sv
// Sequences one CHIP-8 8XYN instruction: read Vx/Vy, drive the shared ALU,
// write back Vx and then (if the op sets it) VF, then pulse done.
// Ports: clk, rst_n (async active-low); start/opcode request; busy, done,
// illegal status; rf_raddr_a/b + rf_rdata_a/b V-file reads (1-cycle
// latency); rf_we/rf_waddr/rf_wdata V-file write; alu_a/alu_b/alu_op to and
// alu_out/alu_vf_we/alu_flag from the ALU.
// Option: CHIP8_QUIRK_VF_RESET_EN makes OR/AND/XOR also write VF=0.
// alu_a/alu_b/alu_op are gated combinationally from the state register so
// that read data reaches the ALU in the EXEC cycle itself.
module chip8_alu_sequencer
  import chip8_pkg::*;
#(
  parameter int unsigned      RF_RD_LAT = 1,
  parameter logic [NIB_W-1:0] VF_IDX    = C8_VF_IDX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OPC_W-1:0]  opcode,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [NIB_W-1:0]  rf_raddr_a,
  output logic [NIB_W-1:0]  rf_raddr_b,
  input  logic [DATA_W-1:0] rf_rdata_a,
  input  logic [DATA_W-1:0] rf_rdata_b,
  output logic              rf_we,
  output logic [NIB_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [NIB_W-1:0]  alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_vf_we,
  input  logic              alu_flag
);

  seq_state_e state_q, state_d;

  logic [NIB_W-1:0]  x_q, x_d, y_q, y_d, n_q, n_d;
  logic              vfr_q, vfr_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              flag_q, flag_d;
  logic              fwe_q, fwe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;
  logic [NIB_W-1:0]  raddr_a_q, raddr_a_d, raddr_b_q, raddr_b_d;
  logic              we_q, we_d;
  logic [NIB_W-1:0]  waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [NIB_W-1:0]  dec_x, dec_y, dec_n;
  logic              dec_legal, dec_vfr;

  chip8_8xy_decode u_decode (
    .opcode         (opcode),
    .x              (dec_x),
    .y              (dec_y),
    .n              (dec_n),
    .legal          (dec_legal),
    .needs_vf_reset (dec_vfr)
  );

  // Only single-cycle register-file reads are supported
  rf_rd_lat_chk: assert property (@(posedge clk) RF_RD_LAT == 1);

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      n_q       <= '0;
      vfr_q     <= 1'b0;
      result_q  <= '0;
      flag_q    <= 1'b0;
      fwe_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      raddr_a_q <= '0;
      raddr_b_q <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      n_q       <= n_d;
      vfr_q     <= vfr_d;
      result_q  <= result_d;
      flag_q    <= flag_d;
      fwe_q     <= fwe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      raddr_a_q <= raddr_a_d;
      raddr_b_q <= raddr_b_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  // Next state, datapath captures, and next values of registered outputs
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    n_d       = n_q;
    vfr_d     = vfr_q;
    result_d  = result_q;
    flag_d    = flag_q;
    fwe_d     = fwe_q;
    illegal_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d   = dec_x;
          y_d   = dec_y;
          n_d   = dec_n;
          vfr_d = dec_vfr;
          if (dec_legal) begin
            state_d = ST_READ;
          end else begin
            state_d   = ST_DONE;
            illegal_d = 1'b1;
          end
        end
      end
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: begin
        result_d = alu_out;
        flag_d   = vfr_q ? 1'b0 : alu_flag;
        fwe_d    = alu_vf_we | vfr_q;
        state_d  = ST_WB_X;
      end
      ST_WB_X: state_d = fwe_q ? ST_WB_F : ST_DONE;
      ST_WB_F: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    raddr_a_d = '0;
    raddr_b_d = '0;
    if ((state_d == ST_READ) || (state_d == ST_EXEC)) begin
      raddr_a_d = x_d;
      raddr_b_d = y_d;
    end
    we_d    = 1'b0;
    waddr_d = '0;
    wdata_d = '0;
    if (state_d == ST_WB_X) begin
      we_d    = 1'b1;
      waddr_d = x_d;
      wdata_d = result_d;
    end else if (state_d == ST_WB_F) begin
      we_d    = 1'b1;
      waddr_d = VF_IDX;
      wdata_d = {{(DATA_W-1){1'b0}}, flag_d};
    end
  end

  // ALU operands are held at zero outside EXEC
  assign alu_a  = (state_q == ST_EXEC) ? rf_rdata_a : '0;
  assign alu_b  = (state_q == ST_EXEC) ? rf_rdata_b : '0;
  assign alu_op = (state_q == ST_EXEC) ? n_q : '0;

  assign busy       = busy_q;
  assign done       = done_q;
  assign illegal    = illegal_q;
  assign rf_raddr_a = raddr_a_q;
  assign rf_raddr_b = raddr_b_q;
  assign rf_we      = we_q;
  assign rf_waddr   = waddr_q;
  assign rf_wdata   = wdata_q;

endmodule

// File: tb/tb_chip8_alu_sequencer.sv
// Bench for chip8_alu_sequencer: models the V-file and ALU around the DUT,
// predicts the write/done event stream per instruction, and checks it with a
// scoreboard monitor.
module tb_chip8_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] opcode = 16'h0;
  logic        busy, done, illegal;
  logic [3:0]  rf_raddr_a, rf_raddr_b;
  logic [7:0]  rf_rdata_a, rf_rdata_b;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [7:0]  rf_wdata;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [7:0]  alu_out;
  logic        alu_vf_we, alu_flag;

  always #5 clk = ~clk;

  chip8_alu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .busy(busy), .done(done), .illegal(illegal),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_vf_we(alu_vf_we), .alu_flag(alu_flag)
  );

  // V-file: 1-cycle read latency, DUT write port plus a bench preload port
  logic [7:0] regs [16];
  logic       pre_we = 1'b0;
  logic [3:0] pre_addr = 4'h0;
  logic [7:0] pre_data = 8'h0;
  int         edge_n = 0;

  always @(posedge clk) begin
    rf_rdata_a <= regs[rf_raddr_a];
    rf_rdata_b <= regs[rf_raddr_b];
    if (rf_we) regs[rf_waddr] <= rf_wdata;
    else if (pre_we) regs[pre_addr] <= pre_data;
    edge_n <= edge_n + 1;
  end

  // ALU stub
  always_comb begin
    alu_out   = 8'h00;
    alu_flag  = 1'b0;
    alu_vf_we = 1'b0;
    case (alu_op)
      4'h0: alu_out = alu_b;
      4'h1: alu_out = alu_a | alu_b;
      4'h2: alu_out = alu_a & alu_b;
      4'h3: alu_out = alu_a ^ alu_b;
      4'h4: begin {alu_flag, alu_out} = {1'b0, alu_a} + {1'b0, alu_b}; alu_vf_we = 1'b1; end
      4'h5: begin alu_out = alu_a - alu_b; alu_flag = (alu_a >= alu_b); alu_vf_we = 1'b1; end
      4'h6: begin alu_out = {1'b0, alu_a[7:1]}; alu_flag = alu_a[0]; alu_vf_we = 1'b1; end
      4'h7: begin alu_out = alu_b - alu_a; alu_flag = (alu_b >= alu_a); alu_vf_we = 1'b1; end
      4'hE: begin alu_out = {alu_a[6:0], 1'b0}; alu_flag = alu_a[7]; alu_vf_we = 1'b1; end
      default: ;
    endcase
  end

  typedef struct {
    bit       is_done;
    bit [3:0] addr;
    bit [7:0] data;
    bit       ill;
    int       at_edge;
  } ev_t;

  ev_t exp_q[$];
  int  model_rf [16];
  int  checks = 0;
  int  failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: CHIP-8 8XYN semantics in plain integer arithmetic
  task automatic model_push(input logic [15:0] opc, input int acc);
    int  hi, xi, yi, ni, vx, vy, r, f;
    bit  fw, legal;
    ev_t e;
    hi = int'(opc[15:12]); xi = int'(opc[11:8]);
    yi = int'(opc[7:4]);   ni = int'(opc[3:0]);
    vx = model_rf[xi]; vy = model_rf[yi];
    legal = (hi == 8) && (ni <= 7 || ni == 14);
    if (!legal) begin
      e = '{1'b1, 4'h0, 8'h0, 1'b1, acc + 1};
      exp_q.push_back(e);
      return;
    end
    r = 0; f = 0; fw = 1'b1;
    case (ni)
      0: begin r = vy; fw = 1'b0; end
      1: begin r = vx | vy; fw = 1'b0; end
      2: begin r = vx & vy; fw = 1'b0; end
      3: begin r = vx ^ vy; fw = 1'b0; end
      4: begin r = (vx + vy) % 256; f = (vx + vy > 255) ? 1 : 0; end
      5: begin r = (vx - vy + 256) % 256; f = (vx >= vy) ? 1 : 0; end
      6: begin r = vx / 2; f = vx % 2; end
      7: begin r = (vy - vx + 256) % 256; f = (vy >= vx) ? 1 : 0; end
      default: begin r = (vx * 2) % 256; f = (vx >= 128) ? 1 : 0; end
    endcase
`ifdef CHIP8_QUIRK_VF_RESET_EN
    if (ni >= 1 && ni <= 3) begin fw = 1'b1; f = 0; end
`endif
    e = '{1'b0, 4'(xi), 8'(r), 1'b0, acc + 3};
    exp_q.push_back(e);
    model_rf[xi] = r;
    if (fw) begin
      e = '{1'b0, 4'hF, 8'(f), 1'b0, acc + 4};
      exp_q.push_back(e);
      model_rf[15] = f;
    end
    e = '{1'b1, 4'h0, 8'h0, 1'b0, acc + (fw ? 5 : 4)};
    exp_q.push_back(e);
  endtask

  // Monitor: pop expected events whenever the DUT writes or signals done
  initial forever begin
    ev_t e;
    @(negedge clk);
    if (rst_n) begin
      if (!done) chk("illegal_without_done", 32'(illegal), 32'd0);
      if (!busy) begin
        chk("idle_alu_a", 32'(alu_a), 32'd0);
        chk("idle_alu_op", 32'(alu_op), 32'd0);
        chk("idle_rf_we", 32'(rf_we), 32'd0);
      end
      if (rf_we) begin
        if (exp_q.size() == 0) chk("unexpected_write", 32'(rf_waddr), 32'hDEAD);
        else begin
          e = exp_q.pop_front();
          chk("write_kind", 32'(e.is_done), 32'd0);
          chk("write_addr", 32'(rf_waddr), 32'(e.addr));
          chk("write_data", 32'(rf_wdata), 32'(e.data));
          chk("write_cycle", 32'(edge_n), 32'(e.at_edge));
        end
      end
      if (done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 32'(illegal), 32'hDEAD);
        else begin
          e = exp_q.pop_front();
          chk("done_kind", 32'(e.is_done), 32'd1);
          chk("done_illegal", 32'(illegal), 32'(e.ill));
          chk("done_cycle", 32'(edge_n), 32'(e.at_edge));
          chk("done_busy", 32'(busy), 32'd1);
        end
      end
    end
  end

  task automatic preload(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
    model_rf[a] = int'(d);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  // Issue one opcode; optionally pulse a second start at cycle 2
  task automatic run_op(input logic [15:0] opc, input bit poke, input logic [15:0] poke_opc);
    @(negedge clk);
    start = 1'b1; opcode = opc;
    @(posedge clk);
    model_push(opc, edge_n);
    @(negedge clk);
    start = 1'b0;
    if (poke) begin
      @(negedge clk);
      start = 1'b1; opcode = poke_opc;
      @(negedge clk);
      start = 1'b0;
    end
    drain();
  endtask

  initial begin
    #100000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  rx, ry, rn;
    logic [15:0] opc;
    // reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_outs", 32'({rf_raddr_a, rf_raddr_b, rf_waddr, rf_wdata, alu_op}), 32'd0);
    chk("rst_alu", 32'({alu_a, alu_b, illegal}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) preload(4'(i), 8'(i * 17));

    // directed cases
    preload(4'h1, 8'hF0); preload(4'h2, 8'h20);
    run_op(16'h8124, 1'b0, 16'h0);
    preload(4'h3, 8'h10); preload(4'h4, 8'h20);
    run_op(16'h8345, 1'b0, 16'h0);
    preload(4'hF, 8'h05); preload(4'h1, 8'h03);
    run_op(16'h8F14, 1'b0, 16'h0);
    preload(4'h5, 8'hAA); preload(4'h6, 8'h0F);
    run_op(16'h8562, 1'b0, 16'h0);
    run_op(16'h8129, 1'b0, 16'h0);
    run_op(16'h7123, 1'b0, 16'h0);
    run_op(16'h8223, 1'b0, 16'h0);
    // start while busy is ignored
    preload(4'h3, 8'h10); preload(4'h4, 8'h20);
    run_op(16'h8345, 1'b1, 16'h8129);

    // reset during WB_X aborts the op
    preload(4'h1, 8'hF0); preload(4'h2, 8'h20); preload(4'hF, 8'h55);
    @(negedge clk);
    start = 1'b1; opcode = 16'h8124;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("wbx_we_before_reset", 32'(rf_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_outs", 32'({rf_we, rf_waddr, rf_wdata, done, illegal}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_vx_kept", 32'(regs[1]), 32'(model_rf[1]));
    chk("abort_vf_kept", 32'(regs[15]), 32'(model_rf[15]));
    run_op(16'h8124, 1'b0, 16'h0);

    // randomized ops
    for (int k = 0; k < 40; k++) begin
      rx = 4'($urandom_range(0, 15));
      ry = 4'($urandom_range(0, 15));
      rn = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                       : (($urandom_range(0, 8) == 8) ? 4'hE
                                                                      : 4'($urandom_range(0, 7)));
      opc = {4'h8, rx, ry, rn};
      if ($urandom_range(0, 9) == 0) opc[15:12] = 4'($urandom_range(0, 15));
      preload(rx, 8'($urandom_range(0, 255)));
      preload(ry, 8'($urandom_range(0, 255)));
      run_op(opc, 1'b0, 16'h0);
    end

    for (int i = 0; i < 16; i++) chk("final_rf", 32'(regs[i]), 32'(model_rf[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
